jt12_mixacc: RTL and testbench

Stereo channel accumulator for the FM output path. Receives one time-multiplexed signed channel sample per enabled slot, applies the per-channel left/right pan enables, and sums each side over a sample frame. At each frame boundary it presents a registered stereo pair, which feeds the limiting amplifier stage directly. It also checks that the slot sequence stays in step with the frame.

---
 rtl/jt12_mixacc_if.sv | 27 ++
 rtl/jt12_mixacc.sv | 96 +++++++++
 tb/tb_jt12_mixacc.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/jt12_mixacc_if.sv
// Slot-input / stereo-output bundle for jt12_mixacc.
// master: the slot sequencer driving samples and observing the stereo pair.
// slave:  the accumulator itself.
interface jt12_mixacc_if #(
  parameter int in_width = 18,
  parameter int width    = 20
);
  logic                       clk_en;
  logic                       zero;
  logic signed [in_width-1:0] ch_data;
  logic                       ch_left;
  logic                       ch_right;
  logic signed [width-1:0]    left_out;
  logic signed [width-1:0]    right_out;
  logic                       sample;
  logic                       sync_err;

  modport master (
    output clk_en, zero, ch_data, ch_left, ch_right,
    input  left_out, right_out, sample, sync_err
  );

  modport slave (
    input  clk_en, zero, ch_data, ch_left, ch_right,
    output left_out, right_out, sample, sync_err
  );
endinterface

// File: rtl/jt12_mixacc.sv
// Stereo channel accumulator for the FM output path.
// One signed slot per clk_en cycle is panned and summed per side; at each
// frame boundary (zero=1) the finished sums are latched to the outputs and
// the accumulators restart with the boundary slot.
// Build option: define JT12_MIXACC_SAT_EN to saturate each addition instead
// of wrapping (wrap matches the original chip).
module jt12_mixacc #(
  parameter int in_width = 18,
  parameter int width    = 20,
  parameter int channels = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  jt12_mixacc_if.slave     bus
);

  localparam int cw = $clog2(channels + 1);

  logic [cw-1:0]            slot_cnt;
  logic                     full;
  logic [1:0]               pan;
  logic [1:0][width-1:0]    side_out;

  // slot index 1..channels is legal; a further non-boundary slot is an overrun
  assign full = (slot_cnt == cw'(channels));
  assign pan  = {bus.ch_right, bus.ch_left};

  // side 0 = left, side 1 = right; identical datapath per side
  for (genvar s = 0; s < 2; s++) begin : g_side
    logic signed [width-1:0] acc;
    logic signed [width-1:0] out_r;
    logic signed [width-1:0] ext;
    logic signed [width-1:0] nxt;
`ifdef JT12_MIXACC_SAT_EN
    logic signed [width:0]   sum;
`endif

    // pan-gated, sign-extended contribution and the next running sum
    always_comb begin
      ext = pan[s] ? width'(bus.ch_data) : '0;
`ifdef JT12_MIXACC_SAT_EN
      sum = {acc[width-1], acc} + {ext[width-1], ext};
      if (sum[width] != sum[width-1])
        nxt = sum[width] ? {1'b1, {(width-1){1'b0}}} : {1'b0, {(width-1){1'b1}}};
      else
        nxt = sum[width-1:0];
`else
      // two's-complement wrap: dropping the carry of the width+1 sum
      nxt = acc + ext;
`endif
    end

    // boundary latches the finished sum; otherwise accumulate while in range
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        acc   <= '0;
        out_r <= '0;
      end else if (bus.clk_en) begin
        if (bus.zero) begin
          out_r <= acc;
          acc   <= ext;
        end else if (!full) begin
          acc   <= nxt;
        end
      end
    end

    assign side_out[s] = out_r;
  end

  assign bus.left_out  = side_out[0];
  assign bus.right_out = side_out[1];

  // slot counter, frame pulse and overrun flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt     <= '0;
      bus.sample   <= 1'b0;
      bus.sync_err <= 1'b0;
    end else begin
      bus.sample <= 1'b0;
      if (bus.clk_en) begin
        if (bus.zero) begin
          slot_cnt     <= cw'(1);
          bus.sync_err <= 1'b0;
          bus.sample   <= 1'b1;
        end else if (!full) begin
          slot_cnt     <= slot_cnt + cw'(1);
        end else begin
          bus.sync_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_jt12_mixacc.sv
// Self-checking bench for jt12_mixacc: frame table, hand-written corner
// sequences and a randomized run against a frame-level reference model.
module tb_jt12_mixacc;
  localparam int IW = 18;
  localparam int W  = 20;
  localparam int CH = 6;
  localparam longint MAXV = (64'sd1 <<< (W-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (W-1));

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  jt12_mixacc_if #(.in_width(IW), .width(W)) bus ();
  jt12_mixacc #(.in_width(IW), .width(W), .channels(CH)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // reference model state: running side sums, slots seen in frame, outputs
  longint m_accl, m_accr, m_lo, m_ro;
  int     m_slots;
  bit     m_err, m_smp;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  function automatic longint addw(input longint a, input longint b);
    longint s;
    s = a + b;
`ifdef JT12_MIXACC_SAT_EN
    if (s > MAXV) s = MAXV;
    if (s < MINV) s = MINV;
`else
    s = s & ((64'sd1 <<< W) - 1);
    if (s > MAXV) s = s - (64'sd1 <<< W);
`endif
    return s;
  endfunction

  task automatic model_reset();
    m_accl = 0; m_accr = 0; m_lo = 0; m_ro = 0;
    m_slots = 0; m_err = 0; m_smp = 0;
  endtask

  // apply one clk cycle of input, advance the model, compare all outputs
  task automatic step(input bit en, input bit z, input int d, input bit l, input bit r);
    longint cl, cr;
    logic [31:0] dv;
    dv = d;
    bus.clk_en = en; bus.zero = z; bus.ch_data = dv[IW-1:0];
    bus.ch_left = l; bus.ch_right = r;
    @(posedge clk);
    cl = l ? longint'(d) : 0;
    cr = r ? longint'(d) : 0;
    m_smp = 0;
    if (en) begin
      if (z) begin
        m_lo = m_accl; m_ro = m_accr;
        m_accl = cl; m_accr = cr;
        m_slots = 1; m_err = 0; m_smp = 1;
      end else if (m_slots < CH) begin
        m_accl = addw(m_accl, cl);
        m_accr = addw(m_accr, cr);
        m_slots++;
      end else begin
        m_err = 1;
      end
    end
    #1;
    chk("left_out",  longint'(bus.left_out),  m_lo);
    chk("right_out", longint'(bus.right_out), m_ro);
    chk("sample",    longint'(bus.sample),    longint'(m_smp));
    chk("sync_err",  longint'(bus.sync_err),  longint'(m_err));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.clk_en = 0; bus.zero = 0; bus.ch_data = '0; bus.ch_left = 0; bus.ch_right = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
  endtask

  typedef struct {
    string  name;
    int     d[6];
    bit [5:0] lm;
    bit [5:0] rm;
    longint el;
    longint er;
  } vec_t;

  vec_t tbl[4];

  initial begin
    tbl[0] = '{"sum", '{100, 200, 300, 400, 500, 600}, 6'b111111, 6'b111111, 2100, 2100};
    tbl[1] = '{"pan", '{100, 200, 300, 400, 500, 600}, 6'b101111, 6'b111011, 1600, 1800};
`ifdef JT12_MIXACC_SAT_EN
    tbl[2] = '{"ovf_pos", '{131071, 131071, 131071, 131071, 131071, 131071}, 6'b111111, 6'b111111, 524287, 524287};
    tbl[3] = '{"ovf_neg", '{-131072, -131072, -131072, -131072, -131072, -131072}, 6'b111111, 6'b111111, -524288, -524288};
`else
    tbl[2] = '{"ovf_pos", '{131071, 131071, 131071, 131071, 131071, 131071}, 6'b111111, 6'b111111, -262150, -262150};
    tbl[3] = '{"ovf_neg", '{-131072, -131072, -131072, -131072, -131072, -131072}, 6'b111111, 6'b111111, 262144, 262144};
`endif

    do_reset();
    chk("rst_left",   longint'(bus.left_out),  0);
    chk("rst_sample", longint'(bus.sample),    0);
    chk("rst_err",    longint'(bus.sync_err),  0);

    // table frames: slot 0 rides on the boundary, its zero outputs the prior frame
    for (int i = 0; i < 4; i++) begin
      step(1, 1, tbl[i].d[0], tbl[i].lm[0], tbl[i].rm[0]);
      if (i > 0) begin
        chk({tbl[i-1].name, "_l"}, longint'(bus.left_out),  tbl[i-1].el);
        chk({tbl[i-1].name, "_r"}, longint'(bus.right_out), tbl[i-1].er);
      end
      for (int k = 1; k < 6; k++)
        step(1, 0, tbl[i].d[k], tbl[i].lm[k], tbl[i].rm[k]);
    end
    step(1, 1, 0, 0, 0);
    chk({tbl[3].name, "_l"}, longint'(bus.left_out),  tbl[3].el);
    chk({tbl[3].name, "_r"}, longint'(bus.right_out), tbl[3].er);
    chk("sample_hi", longint'(bus.sample), 1);
    step(1, 0, 0, 0, 0);
    chk("sample_one_clk", longint'(bus.sample), 0);

    // asynchronous reset mid-frame with nonzero outputs and accumulators
    step(1, 1, 1000, 1, 1);
    step(1, 0, 2000, 1, 1);
    step(1, 1, 5, 1, 1);
    step(1, 0, 7, 1, 1);
    #1 rst_n = 1'b0;
    #2;
    chk("async_rst_left",  longint'(bus.left_out),  0);
    chk("async_rst_right", longint'(bus.right_out), 0);
    chk("async_rst_err",   longint'(bus.sync_err),  0);
    model_reset();
    step(0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    step(1, 1, 0, 1, 1);
    chk("first_zero_l", longint'(bus.left_out), 0);
    chk("first_zero_s", longint'(bus.sample),   1);

    // overrun: seven slots of 10 straight out of reset
    do_reset();
    for (int k = 0; k < 6; k++) step(1, 0, 10, 1, 1);
    chk("no_err_6", longint'(bus.sync_err), 0);
    step(1, 0, 10, 1, 1);
    chk("err_7", longint'(bus.sync_err), 1);
    step(0, 0, 10, 1, 1);
    chk("err_holds", longint'(bus.sync_err), 1);
    step(1, 1, 0, 1, 1);
    chk("overrun_out", longint'(bus.left_out), 60);
    chk("err_clear",   longint'(bus.sync_err), 0);

    // gated slots: gaps of 1..5 idle cycles, zero held high inside a gap
    for (int k = 0; k < 6; k++) begin
      step(1, (k == 0), (k + 1) * 100, 1, 1);
      for (int g = 0; g < 1 + (k % 5); g++) step(0, (g == 0), 77, 1, 1);
    end
    step(1, 1, 0, 1, 1);
    chk("gated_l", longint'(bus.left_out),  2100);
    chk("gated_r", longint'(bus.right_out), 2100);

    // randomized run, half the time near full scale to reach overflow
    for (int n = 0; n < 1500; n++) begin
      int d;
      bit big;
      big = ($urandom_range(0, 1) == 1);
      if (big) d = ($urandom_range(0, 1) == 1) ? 131071 - int'($urandom_range(0, 15))
                                               : -131072 + int'($urandom_range(0, 15));
      else     d = int'($urandom_range(0, 262143)) - 131072;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, d,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
